multicycle_controller: RTL and testbench

- Control FSM for the 8-bit accumulator datapath. Sits directly upstream of the datapath register bank: opcode (3b), address-high (5b), address-low (8b), PC (13b) and accumulator (8b).
- Generates every register write enable, the memory request/handshake, and the mux/ALU selects.
- Fetches two-byte instructions and sequences one instruction at a time.
- Instruction format: byte 0 = {opcode[7:5], addr_hi[4:0]}; byte 1 = addr_lo[7:0]. Target address = {addr_hi, addr_lo} (13 bits).

---
 rtl/multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the 8-bit accumulator datapath. Fetches two-byte
// instructions ({opcode, addr_hi} then addr_lo), decodes them and sequences
// the single memory operation each one needs. Every datapath register write
// enable, the memory request and the mux/ALU selects are produced here.
//
// Only the state register and the wait counter are registered. All outputs
// are decoded combinationally from the state, opcode, zero and mem_ready.
// Memory completes a transaction in any cycle where mem_req and mem_ready
// are both high, so the completing enables line up with that same cycle.
//
// A watchdog counts consecutive mem_ready-low cycles within one memory
// transaction. Once WAIT_MAX of them have passed and memory is still not
// ready, the controller parks in ERR until reset. WAIT_MAX = 0 disables it.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous reset, active low
//   run        in   1  permits fetching new instructions (sampled at
//                      instruction boundaries only)
//   opcode     in   3  output of the opcode register
//   zero       in   1  accumulator == 0
//   mem_ready  in   1  memory completes the current transaction
//   mem_req    out  1  memory transaction request
//   mem_we     out  1  1 = write, 0 = read
//   iord       out  1  memory address select: 0 = PC, 1 = {addr_hi, addr_lo}
//   opc_wen    out  1  opcode register write enable
//   adrh_wen   out  1  address-high register write enable
//   adrl_wen   out  1  address-low register write enable
//   pc_wen     out  1  PC write enable
//   pc_src     out  1  PC next value: 0 = PC+1, 1 = target address
//   acc_wen    out  1  accumulator write enable
//   alu_op     out  3  ALU function (opcode while acc_wen=1, else 0)
//   busy       out  1  high in every state except IDLE and ERR
//   err        out  1  high in ERR only
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       opc_wen,
    output logic       adrh_wen,
    output logic       adrl_wen,
    output logic       pc_wen,
    output logic       pc_src,
    output logic       acc_wen,
    output logic [2:0] alu_op,
    output logic       busy,
    output logic       err
);

    // Opcode map
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    // Watchdog limit at counter width; a zero limit switches the check off.
    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);
    localparam logic             WD_EN      = (WAIT_MAX > 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_FETCH_LO = 3'd2,
        S_DECODE   = 3'd3,
        S_MEM_RD   = 3'd4,
        S_MEM_WR   = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             req_state_s;
    logic             timeout_s;
    logic             next_instr_s;

    // States that hold a memory request open
    assign req_state_s = (state_r == S_FETCH_HI) || (state_r == S_FETCH_LO) ||
                         (state_r == S_MEM_RD)   || (state_r == S_MEM_WR);

    // Memory still not ready after WAIT_MAX low cycles already counted.
    // A ready in the same cycle wins, so mem_ready is part of the term.
    assign timeout_s = WD_EN && req_state_s && !mem_ready && (cnt_r == WAIT_MAX_C);

    // Where to go at an instruction boundary: run is only looked at here
    assign next_instr_s = run;

    // State register and wait counter, asynchronously cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Wait counter: counts stalled request cycles. Every request state is
    // entered either from a non-request state or from a completion, both of
    // which leave the counter at zero, so clearing on "not stalled" covers
    // both the entry and the completion clear.
    always_comb begin
        cnt_next_s = '0;
        if (req_state_s && !mem_ready && !timeout_s) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = '0;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next_s = state_r;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        opc_wen      = 1'b0;
        adrh_wen     = 1'b0;
        adrl_wen     = 1'b0;
        pc_wen       = 1'b0;
        pc_src       = 1'b0;
        acc_wen      = 1'b0;
        busy         = 1'b0;
        err          = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_next_s = S_FETCH_HI;
                end else begin
                    state_next_s = S_IDLE;
                end
            end

            // First instruction byte: opcode and address-high, PC advances
            S_FETCH_HI: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    opc_wen      = 1'b1;
                    adrh_wen     = 1'b1;
                    pc_wen       = 1'b1;
                    state_next_s = S_FETCH_LO;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_FETCH_HI;
                end
            end

            // Second instruction byte: address-low, PC advances again
            S_FETCH_LO: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    adrl_wen     = 1'b1;
                    pc_wen       = 1'b1;
                    state_next_s = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_FETCH_LO;
                end
            end

            // Register-only instructions finish here; memory ones move on
            S_DECODE: begin
                busy = 1'b1;
                case (opcode)
                    OP_JMP: begin
                        pc_wen       = 1'b1;
                        pc_src       = 1'b1;
                        state_next_s = next_instr_s ? S_FETCH_HI : S_IDLE;
                    end
                    OP_JZ: begin
                        pc_wen       = zero;
                        pc_src       = 1'b1;
                        state_next_s = next_instr_s ? S_FETCH_HI : S_IDLE;
                    end
                    OP_NOT: begin
                        acc_wen      = 1'b1;
                        state_next_s = next_instr_s ? S_FETCH_HI : S_IDLE;
                    end
                    OP_STORE: begin
                        state_next_s = S_MEM_WR;
                    end
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: begin
                        state_next_s = S_MEM_RD;
                    end
                    default: begin
                        state_next_s = S_ERR;
                    end
                endcase
            end

            // Operand read; the accumulator captures the ALU result on ready
            S_MEM_RD: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    acc_wen      = 1'b1;
                    state_next_s = next_instr_s ? S_FETCH_HI : S_IDLE;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end

            // Accumulator store; no register changes on completion
            S_MEM_WR: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_next_s = next_instr_s ? S_FETCH_HI : S_IDLE;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end

            // Sticky until reset; run and mem_ready are ignored
            S_ERR: begin
                err          = 1'b1;
                state_next_s = S_ERR;
            end

            // Unreachable encoding: treat as a fault and park in ERR
            default: begin
                state_next_s = S_ERR;
            end
        endcase

        // ALU function only matters while the accumulator is written
        if (acc_wen) begin
            alu_op = opcode;
        end else begin
            alu_op = 3'b000;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed plus randomized bench for multicycle_controller. The reference is
// an instruction-level model: each instruction is expanded into its phases
// (fetch high, fetch low, decode, memory access), each phase contributes a
// number of stalled cycles followed by one completing cycle, and every cycle
// has an expected output vector built from the opcode rules. Outputs are
// sampled on the falling edge; inputs change just after the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic       run;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       opc_wen;
    logic       adrh_wen;
    logic       adrl_wen;
    logic       pc_wen;
    logic       pc_src;
    logic       acc_wen;
    logic [2:0] alu_op;
    logic       busy;
    logic       err;

    logic [13:0] obs;
    int          vectors;
    int          miscompares;

    multicycle_controller #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .opc_wen   (opc_wen),
        .adrh_wen  (adrh_wen),
        .adrl_wen  (adrl_wen),
        .pc_wen    (pc_wen),
        .pc_src    (pc_src),
        .acc_wen   (acc_wen),
        .alu_op    (alu_op),
        .busy      (busy),
        .err       (err)
    );

    assign obs = {mem_req, mem_we, iord, opc_wen, adrh_wen, adrl_wen,
                  pc_wen, pc_src, acc_wen, alu_op, busy, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector, same packing as obs
    function automatic logic [13:0] vec(input logic req, input logic we, input logic ad,
                                        input logic opc, input logic adh, input logic adl,
                                        input logic pcw, input logic pcs, input logic acc,
                                        input logic [2:0] alu, input logic bsy, input logic er);
        return {req, we, ad, opc, adh, adl, pcw, pcs, acc, alu, bsy, er};
    endfunction

    localparam logic [13:0] V_IDLE = 14'd0;

    function automatic logic [13:0] v_req(input logic we, input logic ad);
        return vec(1'b1, we, ad, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    endfunction

    function automatic logic [13:0] v_err();
        return vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    endfunction

    function automatic logic [13:0] v_fhi_done();
        return vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    endfunction

    function automatic logic [13:0] v_flo_done();
        return vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    endfunction

    // Decode cycle: jumps load the target, NOT writes the accumulator
    function automatic logic [13:0] v_decode(input logic [2:0] op, input logic z);
        logic [13:0] v;
        v = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
        if (op == 3'd6) begin
            v = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
        end else if (op == 3'd7) begin
            v = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
        end else if (op == 3'd5) begin
            v = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [13:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, check outputs mid-cycle, advance
    task automatic step(input logic rdy, input logic [13:0] exp, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Whole instruction from its fetch-high cycle onward. Wait counts give
    // the mem_ready-low cycles before each phase completes; run_end is
    // applied from fetch-low on and decides what follows the instruction.
    task automatic do_instr(input logic [2:0] op, input logic z, input int w_hi,
                            input int w_lo, input int w_mem, input logic run_end,
                            input string tag);
        logic mem_op;
        logic is_st;
        opcode = op;
        zero   = z;
        for (int i = 0; i < w_hi; i++) step(1'b0, v_req(1'b0, 1'b0), {tag, "_hi_wait"});
        step(1'b1, v_fhi_done(), {tag, "_hi_done"});
        run = run_end;
        for (int i = 0; i < w_lo; i++) step(1'b0, v_req(1'b0, 1'b0), {tag, "_lo_wait"});
        step(1'b1, v_flo_done(), {tag, "_lo_done"});
        step(rnd_bit(), v_decode(op, z), {tag, "_decode"});
        mem_op = (op <= 3'd4);
        is_st  = (op == 3'd1);
        if (mem_op) begin
            for (int i = 0; i < w_mem; i++) step(1'b0, v_req(is_st, 1'b1), {tag, "_mem_wait"});
            if (is_st) begin
                step(1'b1, v_req(1'b1, 1'b1), {tag, "_wr_done"});
            end else begin
                step(1'b1, vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               op, 1'b1, 1'b0), {tag, "_rd_done"});
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        run         = 1'b0;
        opcode      = 3'b000;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held: everything low even with run and ready asserted
        run = 1'b1;
        step(1'b1, V_IDLE, "reset_hold");
        step(1'b1, V_IDLE, "reset_hold2");

        // Out of reset with run low: stays idle, ready ignored
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 3; i++) step(rnd_bit(), V_IDLE, "idle_run0");
        run = 1'b1;
        step(rnd_bit(), V_IDLE, "idle_to_fetch");

        // Zero-wait LOAD, then JZ not taken and taken, back to back
        do_instr(3'd0, 1'b0, 0, 0, 0, 1'b1, "load0");
        do_instr(3'd7, 1'b0, 0, 0, 0, 1'b1, "jz_nz");
        do_instr(3'd7, 1'b1, 0, 0, 0, 1'b1, "jz_z");
        do_instr(3'd6, 1'b0, 0, 0, 0, 1'b1, "jmp");
        do_instr(3'd5, 1'b1, 0, 0, 0, 1'b1, "not");

        // STORE stalled three cycles in the write
        do_instr(3'd1, 1'b0, 0, 0, 3, 1'b1, "store_wait");

        // ADD with run dropped during fetch-low: completes, then idle
        do_instr(3'd2, 1'b0, 0, 0, 0, 1'b0, "add_rundrop");
        step(rnd_bit(), V_IDLE, "after_drop_idle");
        step(rnd_bit(), V_IDLE, "after_drop_idle2");

        // Watchdog boundary: 15 low cycles then ready still completes
        run = 1'b1;
        step(rnd_bit(), V_IDLE, "idle_to_fetch2");
        do_instr(3'd3, 1'b0, 15, 15, 15, 1'b1, "sub_w15");
        do_instr(3'd1, 1'b1, 2, 15, 15, 1'b1, "store_w15");

        // Randomized instruction stream with short stalls
        for (int n = 0; n < 40; n++) begin
            do_instr(3'($urandom_range(0, 7)), rnd_bit(), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, "rand");
        end

        // Reset during a stalled LOAD read: no accumulator write leaks out
        opcode = 3'd0;
        zero   = 1'b0;
        step(1'b1, v_fhi_done(), "abort_hi");
        step(1'b1, v_flo_done(), "abort_lo");
        step(rnd_bit(), v_decode(3'd0, 1'b0), "abort_decode");
        step(1'b0, v_req(1'b0, 1'b1), "abort_rd_wait");
        mem_ready = 1'b0;
        #1;
        check("abort_rd_before", v_req(1'b0, 1'b1));
        rst = 1'b0;
        #1;
        check("abort_rst_now", V_IDLE);
        mem_ready = 1'b1;
        #1;
        check("abort_rst_ready", V_IDLE);
        @(posedge clk);
        #1;
        check("abort_rst_edge", V_IDLE);
        rst = 1'b1;
        run = 1'b1;
        step(rnd_bit(), V_IDLE, "restart_idle");

        // Restart at fetch-high, then memory never answers: ERR after 16
        for (int i = 0; i < 16; i++) step(1'b0, v_req(1'b0, 1'b0), "wd_stall");
        for (int i = 0; i < 4; i++) step(rnd_bit(), v_err(), "err_hold");

        // Only reset leaves ERR
        rst = 1'b0;
        #1;
        check("err_rst", V_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        step(rnd_bit(), V_IDLE, "final_idle");
        run = 1'b1;
        step(rnd_bit(), V_IDLE, "final_to_fetch");
        step(1'b0, v_req(1'b0, 1'b0), "final_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
